// File: rtl/step_counter.sv
// Up/down counter with programmable step and terminal value, wrapping or saturating
// at the range ends, with registered carry/borrow and clamp pulses.
module step_counter #(
  parameter int WIDTH    = 4,
  parameter int STEP_W   = WIDTH,
  parameter int MAX_VAL  = 2**WIDTH-1,
  parameter bit SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              en,
  input  logic              dir,
  input  logic [STEP_W-1:0] step,
  output logic [WIDTH-1:0]  count,
  output logic              co,
  output logic              sat,
  output logic              tc
);

  localparam logic [WIDTH:0]   max_ext = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] max_w   = WIDTH'(MAX_VAL);
  // Wraps to zero when MAX_VAL is all ones, which keeps the modular arithmetic exact.
  localparam logic [WIDTH-1:0] modulus = WIDTH'(MAX_VAL + 1);

  logic [WIDTH-1:0] step_w;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] adv_next;
  logic [WIDTH:0]   up_sum;
  logic             adv_cross;

  assign step_w       = WIDTH'(step);
  assign up_sum       = {1'b0, count} + {1'b0, step_w};
  assign load_clamped = ({1'b0, load_val} > max_ext) ? max_w : load_val;
  assign tc           = dir ? (count == '0) : (count == max_w);

  // Wrapped results are computed modulo 2**WIDTH; the true result always lies in 0..MAX_VAL.
  always_comb begin
    adv_next  = count;
    adv_cross = 1'b0;
    if (!dir) begin
      if (up_sum > max_ext) begin
        adv_cross = 1'b1;
        adv_next  = SATURATE ? max_w : (count + step_w - modulus);
      end else begin
        adv_next  = up_sum[WIDTH-1:0];
      end
    end else begin
      if (step_w > count) begin
        adv_cross = 1'b1;
        adv_next  = SATURATE ? '0 : (count + modulus - step_w);
      end else begin
        adv_next  = count - step_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      co    <= 1'b0;
      sat   <= 1'b0;
    end else begin
      co  <= 1'b0;
      sat <= 1'b0;
      if (clr) begin
        count <= '0;
      end else if (load) begin
        count <= load_clamped;
      end else if (en) begin
        count <= adv_next;
        co    <= adv_cross;
        sat   <= SATURATE && adv_cross;
      end
    end
  end

endmodule

// File: tb/tb_step_counter.sv
// Self-checking bench for step_counter: directed scenarios on several configurations
// plus a randomized run compared against a plain-arithmetic reference model.
module tb_step_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       clr = 1'b0, load = 1'b0, en = 1'b0, dir = 1'b0;
  logic [3:0] lv4 = '0, step4 = '0;
  logic [7:0] lv8 = '0, step8 = '0;
  logic [4:0] step5 = '0;

  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic [7:0] cnt_d, cnt_e;
  logic co_a, co_b, co_c, co_d, co_e;
  logic sat_a, sat_b, sat_c, sat_d, sat_e;
  logic tc_a, tc_b, tc_c, tc_d, tc_e;

  logic [7:0] dcount [5];
  logic [4:0] dco, dsat, dtc;

  int checks = 0;
  int failures = 0;

  // Reference model state, one slot per instance
  int mmax [5] = '{15, 9, 12, 200, 255};
  bit msatm [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  int mc [5] = '{0, 0, 0, 0, 0};
  bit mco [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  bit msat [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  step_counter #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv4), .en(en), .dir(dir),
    .step(step4), .count(cnt_a), .co(co_a), .sat(sat_a), .tc(tc_a));
  step_counter #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv4), .en(en), .dir(dir),
    .step(step4), .count(cnt_b), .co(co_b), .sat(sat_b), .tc(tc_b));
  step_counter #(.WIDTH(4), .MAX_VAL(12), .SATURATE(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv4), .en(en), .dir(dir),
    .step(step4), .count(cnt_c), .co(co_c), .sat(sat_c), .tc(tc_c));
  step_counter #(.WIDTH(8), .MAX_VAL(200), .SATURATE(1'b0)) dut_d (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv8), .en(en), .dir(dir),
    .step(step8), .count(cnt_d), .co(co_d), .sat(sat_d), .tc(tc_d));
  step_counter #(.WIDTH(8), .STEP_W(5), .MAX_VAL(255), .SATURATE(1'b1)) dut_e (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(lv8), .en(en), .dir(dir),
    .step(step5), .count(cnt_e), .co(co_e), .sat(sat_e), .tc(tc_e));

  assign dcount[0] = {4'b0, cnt_a};
  assign dcount[1] = {4'b0, cnt_b};
  assign dcount[2] = {4'b0, cnt_c};
  assign dcount[3] = cnt_d;
  assign dcount[4] = cnt_e;
  assign dco  = {co_e, co_d, co_c, co_b, co_a};
  assign dsat = {sat_e, sat_d, sat_c, sat_b, sat_a};
  assign dtc  = {tc_e, tc_d, tc_c, tc_b, tc_a};

  // Steps beyond MAX_VAL+1 are outside the counter's contract
  always @(posedge clk) begin
    if (rst_n && en && !clr && !load)
      assert (step4 <= 4'd10 && step8 <= 8'd201) else $error("[TB] illegal step driven");
  end

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      mc[i] = 0;
      mco[i] = 1'b0;
      msat[i] = 1'b0;
    end
  endtask

  // Advance the model from the current inputs, then step the clock and sample 1 ns later
  task automatic tick();
    int nc [5];
    bit nco [5];
    bit nsat [5];
    for (int i = 0; i < 5; i++) begin
      int mx;
      int st;
      int lv;
      mx = mmax[i];
      st = (i < 3) ? int'(step4) : ((i == 3) ? int'(step8) : int'(step5));
      lv = (i < 3) ? int'(lv4) : int'(lv8);
      nc[i] = mc[i];
      nco[i] = 1'b0;
      nsat[i] = 1'b0;
      if (clr) nc[i] = 0;
      else if (load) nc[i] = (lv > mx) ? mx : lv;
      else if (en) begin
        if (!dir) begin
          if (mc[i] + st > mx) begin
            nco[i] = 1'b1;
            nsat[i] = msatm[i];
            nc[i] = msatm[i] ? mx : mc[i] + st - (mx + 1);
          end else nc[i] = mc[i] + st;
        end else begin
          if (st > mc[i]) begin
            nco[i] = 1'b1;
            nsat[i] = msatm[i];
            nc[i] = msatm[i] ? 0 : mc[i] + (mx + 1) - st;
          end else nc[i] = mc[i] - st;
        end
      end
    end
    @(posedge clk);
    #1;
    if (rst_n) begin
      for (int i = 0; i < 5; i++) begin
        mc[i] = nc[i];
        mco[i] = nco[i];
        msat[i] = nsat[i];
      end
    end else model_reset();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dcount[i] !== 8'd0 || dco[i] !== 1'b0 || dsat[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_initial[%0d] count=%0d co=%b sat=%b required 0/0/0", i, dcount[i], dco[i], dsat[i]);
      end
    end
    #4 rst_n = 1'b1;
    load = 1'b1; lv4 = 4'd9; lv8 = 8'd9;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b0; step4 = 4'd10;
    tick();
    checks++;
    if (cnt_b !== 4'd9 || co_b !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset_b count=%0d co=%b required 9/1", cnt_b, co_b);
    end
    checks++;
    if (cnt_c !== 4'd12 || co_c !== 1'b1 || sat_c !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset_c count=%0d co=%b sat=%b required 12/1/1", cnt_c, co_c, sat_c);
    end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (dcount[i] !== 8'd0 || dco[i] !== 1'b0 || dsat[i] !== 1'b0) begin
        failures++;
        $display("[TB] FAIL async_reset[%0d] count=%0d co=%b sat=%b required 0/0/0", i, dcount[i], dco[i], dsat[i]);
      end
    end
    model_reset();
    checks++;
    if (tc_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_tc_up tc=%b required 0", tc_a);
    end
    dir = 1'b1;
    #1;
    checks++;
    if (tc_a !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_tc_down tc=%b required 1", tc_a);
    end
    rst_n = 1'b1;
    en = 1'b0; dir = 1'b0;
  endtask

  task automatic test_wrap_up();
    int e [7] = '{3, 6, 9, 12, 15, 2, 5};
    bit eco [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    bit etc [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1; dir = 1'b0; step4 = 4'd3;
    for (int k = 0; k < 7; k++) begin
      tick();
      checks++;
      if (int'(cnt_a) != e[k] || co_a !== eco[k] || tc_a !== etc[k] || sat_a !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wrap_up[%0d] count=%0d co=%b tc=%b sat=%b required %0d/%b/%b/0",
                 k, cnt_a, co_a, tc_a, sat_a, e[k], eco[k], etc[k]);
      end
    end
  endtask

  task automatic test_wrap_down();
    int e [4] = '{1, 7, 3, 9};
    bit eco [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    en = 1'b0; load = 1'b1; lv4 = 4'd5;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b1; step4 = 4'd4;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (int'(cnt_b) != e[k] || co_b !== eco[k] || tc_b !== 1'b0) begin
        failures++;
        $display("[TB] FAIL wrap_down[%0d] count=%0d co=%b tc=%b required %0d/%b/0",
                 k, cnt_b, co_b, tc_b, e[k], eco[k]);
      end
    end
  endtask

  task automatic test_saturate();
    int e [6] = '{12, 12, 7, 2, 0, 0};
    bit ef [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit etc [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    en = 1'b0; load = 1'b1; lv4 = 4'd10;
    tick();
    load = 1'b0; en = 1'b1; dir = 1'b0; step4 = 4'd5;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        dir = 1'b1;
        #1;
        checks++;
        if (tc_c !== 1'b0) begin
          failures++;
          $display("[TB] FAIL sat_dir_change_tc tc=%b required 0", tc_c);
        end
      end
      tick();
      checks++;
      if (int'(cnt_c) != e[k] || co_c !== ef[k] || sat_c !== ef[k] || tc_c !== etc[k]) begin
        failures++;
        $display("[TB] FAIL saturate[%0d] count=%0d co=%b sat=%b tc=%b required %0d/%b/%b/%b",
                 k, cnt_c, co_c, sat_c, tc_c, e[k], ef[k], ef[k], etc[k]);
      end
    end
  endtask

  task automatic test_priority();
    clr = 1'b1; load = 1'b1; lv4 = 4'd7; en = 1'b1; dir = 1'b0; step4 = 4'd3;
    tick();
    checks++;
    if (cnt_c !== 4'd0 || co_c !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_clr count=%0d co=%b required 0/0", cnt_c, co_c);
    end
    clr = 1'b0;
    tick();
    checks++;
    if (cnt_c !== 4'd7 || co_c !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_load count=%0d co=%b required 7/0", cnt_c, co_c);
    end
    lv4 = 4'd14;
    tick();
    checks++;
    if (cnt_c !== 4'd12 || cnt_a !== 4'd14 || cnt_b !== 4'd9) begin
      failures++;
      $display("[TB] FAIL load_clamp counts=%0d/%0d/%0d required 12/14/9", cnt_c, cnt_a, cnt_b);
    end
    load = 1'b0;
  endtask

  task automatic test_hold();
    en = 1'b1; step4 = 4'd0; dir = 1'b0;
    tick();
    checks++;
    if (cnt_a !== 4'd14 || co_a !== 1'b0 || cnt_c !== 4'd12 || sat_c !== 1'b0 || co_c !== 1'b0) begin
      failures++;
      $display("[TB] FAIL step_zero_hold a=%0d co=%b c=%0d co=%b sat=%b required 14/0/12/0/0",
               cnt_a, co_a, cnt_c, co_c, sat_c);
    end
    en = 1'b0; step4 = 4'd3;
    tick();
    checks++;
    if (cnt_a !== 4'd14 || co_a !== 1'b0) begin
      failures++;
      $display("[TB] FAIL en_low_hold count=%0d co=%b required 14/0", cnt_a, co_a);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        model_reset();
      end
      clr   = ($urandom_range(0, 99) < 4);
      load  = ($urandom_range(0, 99) < 10);
      en    = ($urandom_range(0, 99) < 75);
      dir   = $urandom_range(0, 1);
      step4 = 4'($urandom_range(0, 10));
      step8 = 8'($urandom_range(0, 201));
      step5 = 5'($urandom);
      lv4   = 4'($urandom);
      lv8   = 8'($urandom);
      tick();
      for (int i = 0; i < 5; i++) begin
        bit etc;
        etc = dir ? (mc[i] == 0) : (mc[i] == mmax[i]);
        checks++;
        if (int'(dcount[i]) != mc[i] || dco[i] !== mco[i] || dsat[i] !== msat[i] || dtc[i] !== etc) begin
          failures++;
          $display("[TB] FAIL random[%0d] dut=%0d count=%0d co=%b sat=%b tc=%b required %0d/%b/%b/%b",
                   n, i, dcount[i], dco[i], dsat[i], dtc[i], mc[i], mco[i], msat[i], etc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_saturate();
    test_priority();
    test_hold();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
